// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, state codes,
// ALUOp / ALUSrcB / PCSource values, and the legal-opcode helper.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQ    = 4'd9,
    S_JMP    = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_control_outdec.sv
// Moore output decoder: current state (plus mem_ready in the handshake states and the
// raw opcode in DECODE) to datapath strobes. Purely combinational.
module mc_control_outdec
  import mc_pkg::*;
(
  input  state_t      state,
  input  logic        mem_ready,
  input  logic [5:0]  opcode,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        instr_done,
  output logic        illegal_op
);

  // Strobe decode; everything defaults low so unlisted strobes stay 0 in each state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        // PC and IR update only in the cycle memory accepts the fetch.
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (!is_legal_op(opcode)) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end else begin
          illegal_op = 1'b0;
        end
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: state register, opcode latch and next-state logic.
// Strobes come combinationally from the current state so reset drops them at once.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [3:0]  state_o
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [5:0]  opcode_r;

  // State register and opcode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      opcode_r <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_DECODE) begin
        opcode_r <= opcode;
      end else begin
        opcode_r <= opcode_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  state_nxt_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_nxt_s = S_DECODE;
        else           state_nxt_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_RTYPE:     state_nxt_s = S_RTEXE;
          OP_BEQ:       state_nxt_s = S_BEQ;
          OP_J:         state_nxt_s = S_JMP;
          OP_ADDI:      state_nxt_s = S_ADDIEX;
          default:      state_nxt_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode_r == OP_SW) state_nxt_s = S_MEMWR;
        else                   state_nxt_s = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) state_nxt_s = S_MEMWB;
        else           state_nxt_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) state_nxt_s = S_FETCH;
        else           state_nxt_s = S_MEMWR;
      end
      S_RTEXE:  state_nxt_s = S_RTWB;
      S_ADDIEX: state_nxt_s = S_ADDIWB;
      S_MEMWB, S_RTWB, S_BEQ, S_JMP, S_ADDIWB: state_nxt_s = S_FETCH;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  assign state_o = state_r;

  mc_control_outdec u_outdec (
    .state         (state_r),
    .mem_ready     (mem_ready),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks every instruction class cycle by cycle
// and compares state and the full strobe vector against hand-written values.
module tb_mc_control_fsm;
  import mc_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [3:0]  state_o;

  int total_checks;
  int passed_checks;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pw pwc ps[2] iord mrd mwr irw rw rdst m2r asa asb[2] aop[2] done ill
  function automatic logic [17:0] mk(input logic pw, input logic pwc, input logic [1:0] ps,
                                     input logic io, input logic mrd, input logic mwr,
                                     input logic irw, input logic rw, input logic rd,
                                     input logic m2r, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic dn, input logic il);
    return {pw, pwc, ps, io, mrd, mwr, irw, rw, rd, m2r, asa, asb, aop, dn, il};
  endfunction

  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                 instr_done, illegal_op};

  logic [17:0] v_zero, v_fetch, v_fetch_wait, v_decode, v_decode_ill, v_memadr, v_memrd;
  logic [17:0] v_memwb, v_memwr_wait, v_memwr_done, v_rtexe, v_rtwb, v_beq, v_jmp, v_addiwb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_checks++;
    assert (obs === expv) passed_checks++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] v);
    chk({tag, "/state"}, 32'(state_o), 32'(st));
    chk({tag, "/outs"},  32'(outs),    32'(v));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    v_zero       = 18'd0;
    v_fetch      = mk(1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0);
    v_fetch_wait = mk(1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0);
    v_decode     = mk(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,1'b0);
    v_decode_ill = mk(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b1,1'b1);
    v_memadr     = mk(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0);
    v_memrd      = mk(1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    v_memwb      = mk(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b1,1'b0);
    v_memwr_wait = mk(1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    v_memwr_done = mk(1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0);
    v_rtexe      = mk(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,1'b0);
    v_rtwb       = mk(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0);
    v_beq        = mk(1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b1,1'b0);
    v_jmp        = mk(1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0);
    v_addiwb     = mk(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0);

    // Reset held three cycles with mem_ready high.
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
    #1; cyc("rst0", 4'd0, v_zero);
    tick(); cyc("rst1", 4'd0, v_zero);
    tick(); cyc("rst2", 4'd0, v_zero);
    tick(); rst = 1'b0; #1; cyc("release", 4'd0, v_zero);

    // R-type, no wait; mem_ready low in RTEXE must be ignored.
    tick(); cyc("rt_fetch", 4'd1, v_fetch);
    tick(); opcode = 6'b000000; #1; cyc("rt_decode", 4'd2, v_decode);
    tick(); mem_ready = 1'b0; opcode = 6'b111111; #1; cyc("rt_exe", 4'd7, v_rtexe);
    tick(); mem_ready = 1'b1; #1; cyc("rt_wb", 4'd8, v_rtwb);

    // lw with two wait cycles in MEMRD.
    tick(); cyc("lw_fetch", 4'd1, v_fetch);
    tick(); opcode = 6'b100011; #1; cyc("lw_decode", 4'd2, v_decode);
    tick(); opcode = 6'b101011; #1; cyc("lw_memadr", 4'd3, v_memadr);
    tick(); mem_ready = 1'b0; #1; cyc("lw_memrd_w1", 4'd4, v_memrd);
    tick(); cyc("lw_memrd_w2", 4'd4, v_memrd);
    tick(); mem_ready = 1'b1; #1; cyc("lw_memrd_ok", 4'd4, v_memrd);
    tick(); mem_ready = 1'b0; #1; cyc("lw_memwb", 4'd5, v_memwb);

    // sw with a fetch wait and a store wait; opcode changes after DECODE.
    tick(); cyc("sw_fetch_wait", 4'd1, v_fetch_wait);
    tick(); mem_ready = 1'b1; #1; cyc("sw_fetch", 4'd1, v_fetch);
    tick(); opcode = 6'b101011; #1; cyc("sw_decode", 4'd2, v_decode);
    tick(); opcode = 6'b100011; #1; cyc("sw_memadr", 4'd3, v_memadr);
    tick(); mem_ready = 1'b0; #1; cyc("sw_memwr_wait", 4'd6, v_memwr_wait);
    tick(); mem_ready = 1'b1; #1; cyc("sw_memwr_done", 4'd6, v_memwr_done);

    // beq then j, three cycles each.
    tick(); cyc("beq_fetch", 4'd1, v_fetch);
    tick(); opcode = 6'b000100; #1; cyc("beq_decode", 4'd2, v_decode);
    tick(); cyc("beq_exec", 4'd9, v_beq);
    tick(); cyc("j_fetch", 4'd1, v_fetch);
    tick(); opcode = 6'b000010; #1; cyc("j_decode", 4'd2, v_decode);
    tick(); cyc("j_exec", 4'd10, v_jmp);

    // addi.
    tick(); cyc("addi_fetch", 4'd1, v_fetch);
    tick(); opcode = 6'b001000; #1; cyc("addi_decode", 4'd2, v_decode);
    tick(); cyc("addi_ex", 4'd11, v_memadr);
    tick(); cyc("addi_wb", 4'd12, v_addiwb);

    // Illegal opcode: two cycles back to FETCH.
    tick(); cyc("ill_fetch", 4'd1, v_fetch);
    tick(); opcode = 6'b111111; #1; cyc("ill_decode", 4'd2, v_decode_ill);
    tick(); cyc("ill_refetch", 4'd1, v_fetch);

    // R-type interrupted by reset in RTWB.
    tick(); opcode = 6'b000000; #1; cyc("ab_decode", 4'd2, v_decode);
    tick(); cyc("ab_exe", 4'd7, v_rtexe);
    tick(); cyc("ab_wb", 4'd8, v_rtwb);
    #2; rst = 1'b1; #1; cyc("ab_rst_async", 4'd0, v_zero);
    tick(); rst = 1'b0; #1; cyc("ab_release", 4'd0, v_zero);
    tick(); cyc("ab_restart", 4'd1, v_fetch);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
